reg_ref_ctrl: RTL

REG_REF_CTRL -- requirements
Module: reg_ref_ctrl

---
 rtl/reg_ref_ctrl_pkg.sv | 22 ++
 rtl/reg_ref_lookup.sv | 47 ++++
 rtl/reg_ref_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/reg_ref_ctrl_pkg.sv
// Shared definitions for the register reference controller.
// Holds the ROB tag width default, architectural register count, the $ra index
// and a population-count helper used to derive ref_count.
package reg_ref_ctrl_pkg;

  localparam int unsigned RobAddrWidthDef = 4;
  localparam int unsigned NumRegs         = 32;
  localparam int unsigned RegAddrWidth    = 5;
  localparam int unsigned DataWidth       = 32;
  localparam int unsigned RefCountWidth   = 6;
  localparam int unsigned RaIdx           = 1;

  function automatic logic [RefCountWidth-1:0] popcount(input logic [NumRegs-1:0] v);
    logic [RefCountWidth-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NumRegs; i++) begin
      cnt = cnt + RefCountWidth'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/reg_ref_lookup.sv
// One decode read port: resolves an architectural source to either a value
// (regfile or same-cycle committing result) or a pending ROB tag.
// Ports:
//   read_en_i, read_addr_i, regfile_data_i : lookup request and regfile value
//   entry_valid_i, entry_tag_i             : rename-table entry for read_addr_i
//   commit_*_i                             : retiring ROB result for bypass
//   is_ref_o, data_o                       : resolved operand
module reg_ref_lookup
  import reg_ref_ctrl_pkg::*;
#(
  parameter int unsigned ROB_ADDR_WIDTH = RobAddrWidthDef
) (
  input  logic                      read_en_i,
  input  logic [RegAddrWidth-1:0]   read_addr_i,
  input  logic [DataWidth-1:0]      regfile_data_i,
  input  logic                      entry_valid_i,
  input  logic [ROB_ADDR_WIDTH-1:0] entry_tag_i,
  input  logic                      commit_en_i,
  input  logic [RegAddrWidth-1:0]   commit_addr_i,
  input  logic [ROB_ADDR_WIDTH-1:0] commit_tag_i,
  input  logic [DataWidth-1:0]      commit_data_i,
  output logic                      is_ref_o,
  output logic [DataWidth-1:0]      data_o
);

  logic bypass;

  // The result leaving the ROB this cycle is the one the entry is waiting for.
  assign bypass = commit_en_i && (commit_addr_i == read_addr_i) &&
                  (commit_tag_i == entry_tag_i);

  always_comb begin
    is_ref_o = 1'b0;
    data_o   = '0;
    if (read_en_i) begin
      if (!entry_valid_i) begin
        data_o = regfile_data_i;
      end else if (bypass) begin
        data_o = commit_data_i;
      end else begin
        is_ref_o = 1'b1;
        data_o   = {{(DataWidth - ROB_ADDR_WIDTH){1'b0}}, entry_tag_i};
      end
    end
  end

endmodule

// File: rtl/reg_ref_ctrl.sv
// Rename table tracking which architectural registers await an in-flight ROB
// result. Two decode read ports look up operands; decode allocates destination
// tags; ROB retirement clears matching entries; flush clears everything.
// Ports:
//   clk, rst (async, active low)
//   read_en_*/read_addr_*/regfile_data_* -> reg_read_is_ref_*/reg_read_data_*
//   alloc_en/alloc_addr/alloc_tag        : destination rename
//   commit_en/commit_addr/commit_tag/commit_data : retirement
//   flush                                : drop all mappings
//   ref_count                            : registered number of valid entries
module reg_ref_ctrl
  import reg_ref_ctrl_pkg::*;
#(
  parameter int unsigned ROB_ADDR_WIDTH = RobAddrWidthDef
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      read_en_1,
  input  logic                      read_en_2,
  input  logic [4:0]                read_addr_1,
  input  logic [4:0]                read_addr_2,
  input  logic [31:0]               regfile_data_1,
  input  logic [31:0]               regfile_data_2,
  output logic                      reg_read_is_ref_1,
  output logic                      reg_read_is_ref_2,
  output logic [31:0]               reg_read_data_1,
  output logic [31:0]               reg_read_data_2,
  input  logic                      alloc_en,
  input  logic [4:0]                alloc_addr,
  input  logic [ROB_ADDR_WIDTH-1:0] alloc_tag,
  input  logic                      commit_en,
  input  logic [4:0]                commit_addr,
  input  logic [ROB_ADDR_WIDTH-1:0] commit_tag,
  input  logic [31:0]               commit_data,
  input  logic                      flush,
  output logic [5:0]                ref_count
);

  logic [NumRegs-1:0]        valid_q, valid_d;
  logic [ROB_ADDR_WIDTH-1:0] tag_q [NumRegs];
  logic [ROB_ADDR_WIDTH-1:0] tag_d [NumRegs];
  logic [RefCountWidth-1:0]  ref_count_q, ref_count_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    // Only the youngest writer's retirement releases the register.
    if (commit_en && valid_q[commit_addr] && (tag_q[commit_addr] == commit_tag)) begin
      valid_d[commit_addr] = 1'b0;
    end
    // Applied after commit so a same-register alloc wins.
    if (alloc_en && (alloc_addr != '0)) begin
      valid_d[alloc_addr] = 1'b1;
      tag_d[alloc_addr]   = alloc_tag;
    end
    if (flush) begin
      valid_d = '0;
    end
    valid_d[0] = 1'b0;
    // Register 0 is never valid, so the count tops out at 31.
    ref_count_d = popcount(valid_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q     <= '0;
      ref_count_q <= '0;
      for (int i = 0; i < NumRegs; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      ref_count_q <= ref_count_d;
      tag_q       <= tag_d;
    end
  end

  assign ref_count = ref_count_q;

  reg_ref_lookup #(
    .ROB_ADDR_WIDTH (ROB_ADDR_WIDTH)
  ) u_lookup_1 (
    .read_en_i      (read_en_1),
    .read_addr_i    (read_addr_1),
    .regfile_data_i (regfile_data_1),
    .entry_valid_i  (valid_q[read_addr_1]),
    .entry_tag_i    (tag_q[read_addr_1]),
    .commit_en_i    (commit_en),
    .commit_addr_i  (commit_addr),
    .commit_tag_i   (commit_tag),
    .commit_data_i  (commit_data),
    .is_ref_o       (reg_read_is_ref_1),
    .data_o         (reg_read_data_1)
  );

  reg_ref_lookup #(
    .ROB_ADDR_WIDTH (ROB_ADDR_WIDTH)
  ) u_lookup_2 (
    .read_en_i      (read_en_2),
    .read_addr_i    (read_addr_2),
    .regfile_data_i (regfile_data_2),
    .entry_valid_i  (valid_q[read_addr_2]),
    .entry_tag_i    (tag_q[read_addr_2]),
    .commit_en_i    (commit_en),
    .commit_addr_i  (commit_addr),
    .commit_tag_i   (commit_tag),
    .commit_data_i  (commit_data),
    .is_ref_o       (reg_read_is_ref_2),
    .data_o         (reg_read_data_2)
  );

endmodule
